// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART TX line among NUM_REQ packet sources
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int PACKET_WIDTH = 4,
    parameter int GAP_BITS     = 1
) (
    input  logic                              clk_baud,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*PACKET_WIDTH*8-1:0] packet,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                done,
    output logic                              busy,
    output logic                              uart_stream
);
    localparam int PW = PACKET_WIDTH;
    localparam int RW = $clog2(NUM_REQ);
    localparam int BW = $clog2(PW) + 1;
    localparam int GW = GAP_BITS > 0 ? $clog2(GAP_BITS + 1) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t state, state_n;
    logic [RW-1:0] rr_ptr, win;
    logic [PW*8-1:0] pkt_q;
    logic [BW-1:0] byte_idx;
    logic [3:0] bit_idx;
    logic [GW-1:0] gap_cnt;
    logic [10:0] shift;
    logic more;
    logic [7:0] nxt_byte;
    int j;
    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction
    assign more = byte_idx != BW'(PW - 1);
    assign nxt_byte = pkt_q[8*(byte_idx + 1'b1) +: 8];
    assign busy = state != IDLE;
    assign uart_stream = state == SHIFT ? shift[0] : 1'b1;
    assign done = state == DONE ? grant : '0;
    // scan from the farthest offset down so the nearest requester to rr_ptr wins
    always_comb begin
        win = '0;
        j = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) win = RW'(j);
        end
        state_n = state;
        case (state)
            IDLE:    state_n = |req ? SHIFT : IDLE;
            SHIFT:   if (bit_idx == 4'd10) state_n = !more ? DONE : (GAP_BITS > 0 ? GAP : SHIFT);
            GAP:     if (gap_cnt == GW'(GAP_BITS - 1)) state_n = SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            pkt_q    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            shift    <= '1;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (|req) begin
                    grant    <= NUM_REQ'(1) << win;
                    pkt_q    <= packet[int'(win)*PW*8 +: PW*8];
                    shift    <= frame(packet[int'(win)*PW*8 +: 8]);
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    rr_ptr   <= (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
                SHIFT: if (bit_idx == 4'd10) begin
                    gap_cnt <= '0;
                    if (more && GAP_BITS == 0) begin
                        shift    <= frame(nxt_byte);
                        bit_idx  <= '0;
                        byte_idx <= byte_idx + 1'b1;
                    end
                end else begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
                GAP: if (gap_cnt == GW'(GAP_BITS - 1)) begin
                    shift    <= frame(nxt_byte);
                    bit_idx  <= '0;
                    byte_idx <= byte_idx + 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                DONE:    grant <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of three scheduler configurations sharing one baud clock
module tb_uart_tx_scheduler;
    logic clk_baud = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_baud = ~clk_baud;
    logic [3:0] req_a, grant_a, done_a;
    logic [31:0] pkt_a;
    logic busy_a, ln_a;
    logic [3:0] req_b, grant_b, done_b;
    logic [127:0] pkt_b;
    logic busy_b, ln_b;
    logic [1:0] req_c, grant_c, done_c;
    logic [31:0] pkt_c;
    logic busy_c, ln_c;
    int n_checks = 0;
    int n_err = 0;
    uart_tx_scheduler #(.NUM_REQ(4), .PACKET_WIDTH(1), .GAP_BITS(1)) dut_a (
        .clk_baud(clk_baud), .rst_n(rst_n), .req(req_a), .packet(pkt_a),
        .grant(grant_a), .done(done_a), .busy(busy_a), .uart_stream(ln_a));
    uart_tx_scheduler #(.NUM_REQ(4), .PACKET_WIDTH(4), .GAP_BITS(1)) dut_b (
        .clk_baud(clk_baud), .rst_n(rst_n), .req(req_b), .packet(pkt_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .uart_stream(ln_b));
    uart_tx_scheduler #(.NUM_REQ(2), .PACKET_WIDTH(2), .GAP_BITS(0)) dut_c (
        .clk_baud(clk_baud), .rst_n(rst_n), .req(req_c), .packet(pkt_c),
        .grant(grant_c), .done(done_c), .busy(busy_c), .uart_stream(ln_c));
    function automatic logic [3:0] gr(input int d);
        return d == 0 ? grant_a : d == 1 ? grant_b : {2'b00, grant_c};
    endfunction
    function automatic logic [3:0] dn(input int d);
        return d == 0 ? done_a : d == 1 ? done_b : {2'b00, done_c};
    endfunction
    function automatic logic ln(input int d);
        return d == 0 ? ln_a : d == 1 ? ln_b : ln_c;
    endfunction
    function automatic logic bs(input int d);
        return d == 0 ? busy_a : d == 1 ? busy_b : busy_c;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // follows one granted packet from its first start bit through DONE and the idle cycle after it;
    // mut 1 drops req in the first bit, mut 2 also inverts every packet bit
    task automatic expect_pkt(input int d, input logic [31:0] bytes, input logic [3:0] g,
                              input int mut, input string tag);
        int pw, gp;
        logic [7:0] v;
        logic [10:0] f;
        pw = d == 1 ? 4 : d == 2 ? 2 : 1;
        gp = d == 2 ? 0 : 1;
        for (int b = 0; b < pw; b++) begin
            v = bytes[b*8 +: 8];
            f = {1'b1, ^v, v, 1'b0};
            for (int i = 0; i < 11; i++) begin
                @(negedge clk_baud);
                chk({tag, "_bit"}, 32'(ln(d)), 32'(f[i]));
                chk({tag, "_grant"}, 32'(gr(d)), 32'(g));
                chk({tag, "_nodone"}, 32'(dn(d)), 0);
                if (b == 0 && i == 0 && mut > 0) begin
                    if (d == 0) req_a = '0; else if (d == 1) req_b = '0; else req_c = '0;
                end
                if (b == 0 && i == 0 && mut > 1) begin
                    if (d == 0) pkt_a = ~pkt_a; else if (d == 1) pkt_b = ~pkt_b; else pkt_c = ~pkt_c;
                end
            end
            if (b < pw - 1) for (int k = 0; k < gp; k++) begin
                @(negedge clk_baud);
                chk({tag, "_gap"}, 32'(ln(d)), 1);
                chk({tag, "_gap_busy"}, 32'(bs(d)), 1);
            end
        end
        @(negedge clk_baud);
        chk({tag, "_done"}, 32'(dn(d)), 32'(g));
        chk({tag, "_done_line"}, 32'(ln(d)), 1);
        chk({tag, "_done_grant"}, 32'(gr(d)), 32'(g));
        chk({tag, "_done_busy"}, 32'(bs(d)), 1);
        @(negedge clk_baud);
        chk({tag, "_idle_done"}, 32'(dn(d)), 0);
        chk({tag, "_idle_grant"}, 32'(gr(d)), 0);
        chk({tag, "_idle_busy"}, 32'(bs(d)), 0);
        chk({tag, "_idle_line"}, 32'(ln(d)), 1);
    endtask
    initial begin
        req_a = '0; req_b = '0; req_c = '0;
        pkt_a = '0; pkt_b = '0; pkt_c = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_baud);
            req_a = ~req_a; req_b = ~req_b; req_c = ~req_c;
            chk("rst_line", 32'({ln_c, ln_b, ln_a}), 32'h7);
            chk("rst_grant", 32'({grant_c, grant_b, grant_a}), 0);
            chk("rst_busy", 32'({busy_c, busy_b, busy_a}), 0);
        end
        @(negedge clk_baud);
        req_a = '0; req_b = '0; req_c = '0;
        rst_n = 1'b1;
        @(negedge clk_baud);
        chk("post_rst_line", 32'({ln_c, ln_b, ln_a}), 32'h7);
        chk("post_rst_done", 32'({done_c, done_b, done_a}), 0);
        req_a = 4'hF;
        for (int k = 0; k < 5; k++) expect_pkt(0, 32'h0, 4'(1 << (k % 4)), k == 4 ? 1 : 0, "rr_a");
        pkt_a[7:0] = 8'hA5;
        req_a = 4'b0001;
        expect_pkt(0, 32'hA5, 4'b0001, 1, "a5");
        pkt_b[32 +: 32] = 32'h44332211;
        req_b = 4'b0010;
        expect_pkt(1, 32'h44332211, 4'b0010, 1, "gap4");
        pkt_b[96 +: 32] = 32'h0FF08001;
        pkt_b[0 +: 32] = 32'hDEADBEEF;
        req_b = 4'b1001;
        expect_pkt(1, 32'h0FF08001, 4'b1000, 2, "latch");
        req_b = 4'b1001;
        expect_pkt(1, 32'h21524110, 4'b0001, 1, "rr_b");
        pkt_c[16 +: 16] = 16'h3C81;
        req_c = 2'b10;
        expect_pkt(2, 32'h3C81, 4'b0010, 1, "nogap");
        pkt_c[0 +: 16] = 16'h7E00;
        req_c = 2'b11;
        expect_pkt(2, 32'h7E00, 4'b0001, 1, "nogap_rr");
        pkt_a = '0;
        req_a = 4'b0010;
        @(negedge clk_baud);
        chk("mid_start", 32'(ln_a), 0);
        chk("mid_grant", 32'(grant_a), 32'h2);
        @(negedge clk_baud);
        chk("mid_d0", 32'(ln_a), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_line", 32'(ln_a), 1);
        chk("async_grant", 32'(grant_a), 0);
        chk("async_busy", 32'(busy_a), 0);
        req_a = 4'b0110;
        pkt_a[15:8] = 8'h5A;
        pkt_a[23:16] = 8'hC3;
        repeat (2) begin
            @(negedge clk_baud);
            chk("rst_nodone", 32'(done_a), 0);
            chk("rst_hold_line", 32'(ln_a), 1);
        end
        rst_n = 1'b1;
        expect_pkt(0, 32'h5A, 4'b0010, 1, "post_rst");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
